display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Drives the time-multiplexed 4-digit 7-segment display of the coffee machine.
- Generates the 2-bit digit-scan code (saida1Contador = MSB, saida2Contador = LSB) consumed by every per-option segment interface block.
- Generates the matching active-low digit anodes, with a prescaler and an anti-ghosting blank gap between digits.
- Only block on the display path that holds state; segment interface blocks stay purely combinational.

Parameters:
- DIV, 50000, clocks per digit slot; legal range 4..2^20; must be a multiple of 4 when DIM_EN is defined.
- BLANK_CYCLES, 2, clocks with all anodes off after each digit change; 0 disables blanking; must be < DIV.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = scanning runs; 0 = display dark, scan position held.
- freeze  input  1  1 = hold current digit (prescaler keeps running).
- saida1Contador  output  1  digit code MSB, registered.
- saida2Contador  output  1  digit code LSB, registered.
- anodo  output  4  active-low digit enables, registered; anodo[i]=0 selects digit i = {saida1Contador,saida2Contador}.
- tick  output  1  one-clock pulse at each slot boundary, registered.
- Interface decision: one clock, named clock; reset named reset, synchronous and active-high.

Behaviour:
- Reset has priority over all inputs on every edge. Reset values:
  - prescaler 0; digit 00 (saida1Contador=0, saida2Contador=0); anodo=4'b1111; tick=0.
  - state BLANK, blank counter loaded with BLANK_CYCLES.
- States:
  - BLANK: anodo=1111.
  - SCAN: anodo = ~(4'b0001 << digit).
  - Only one anode is ever low.
- Prescaler, when enable=1: counts 0..DIV-1 and wraps to 0. On the edge where prescaler==DIV-1:
  - tick<=1 for exactly one cycle; tick=0 at all other times.
  - If freeze=0: digit<=digit+1 mod 4 (11->00); state<=BLANK with blank counter=BLANK_CYCLES. If BLANK_CYCLES=0, state<=SCAN and the anode switches on the same edge as the digit code.
  - If freeze=1: digit holds, state unchanged, no blank gap inserted.
- BLANK: blank counter decrements each enabled clock. The edge on which it reaches 0 moves to SCAN, so exactly BLANK_CYCLES clocks have anodo=1111.
- Digit code changes on the same edge that enters BLANK. Segment lines therefore settle while the display is dark.
- enable=0:
  - Next edge: anodo<=1111, state<=BLANK, blank counter<=BLANK_CYCLES.
  - Prescaler and digit hold; tick=0.
  - After re-enable: BLANK_CYCLES dark clocks, then SCAN on the same digit. Prescaler resumes from its held value.
- freeze and enable both 0: enable rule applies.
- freeze released: next slot boundary advances normally.
- reset during BLANK or SCAN: next edge gives the full reset values; no partial slot is finished.
- Latency from a reset release edge with enable=1 to the first lit anode (1110) is BLANK_CYCLES clocks.

Optional Feature:
- Macro: DISPLAY_SCAN_DIM_EN.
- Defined:
  - Adds input brilho, 2 bits.
  - In SCAN, the anode is driven low only while prescaler < (brilho+1)*DIV/4, and is 1111 otherwise.
  - brilho is sampled every clock.
  - brilho=3 behaves identically to the build without the macro.
- Undefined: no brilho port; full-slot drive as above.

Test Plan:
- DIV=8, BLANK_CYCLES=2: hold reset 3 clocks, release with enable=1 -> anodo=1111 and code 00 for 2 clocks, then anodo=1110; tick=0 throughout.
- Free run 40 clocks -> tick every 8 clocks; codes 00,01,10,11,00; anodes 1110,1101,1011,0111,1110; exactly 2 clocks of 1111 at each change.
- enable=0 for 5 clocks mid-slot on digit 01 -> anodo=1111 from the next edge, code stays 01, no tick; re-enable -> 2 dark clocks, anodo=1101, slot completes the remaining prescaler count.
- freeze=1 at digit 10 for 24 clocks -> tick still pulses 3 times, code stays 10, anodo stays 1011 with no gaps.
- reset asserted during BLANK after the 10->11 transition -> next edge: code 00, anodo=1111, tick=0, prescaler 0.
- DISPLAY_SCAN_DIM_EN, DIV=8, brilho=1 -> per slot anodo low only at prescaler values 2 and 3 (blank covers 0..1); brilho=3 -> identical waveform to the non-dim build.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Digit-scan controller for the 4-digit 7-segment display: prescaled digit code plus active-low anodes
// with a dark gap after each digit change. Optional DISPLAY_SCAN_DIM_EN adds brilho brightness control.
module display_scan_ctrl #(
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       freeze,
`ifdef DISPLAY_SCAN_DIM_EN
  input  logic [1:0] brilho,
`endif
  output logic       saida1Contador,
  output logic       saida2Contador,
  output logic [3:0] anodo,
  output logic       tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SCAN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      digit_q, digit_d;
  logic [BW-1:0]   blank_q, blank_d;
  logic [3:0]      anodo_q, anodo_d;
  logic            tick_q, tick_d;
  logic            wrap_s;
  logic            lit_s;
`ifdef DISPLAY_SCAN_DIM_EN
  logic [21:0]     thr_s;
`endif

  // Next-state: prescaler, digit advance, blank gap and the anode pattern for the coming cycle
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    digit_d = digit_q;
    blank_d = blank_q;
    tick_d  = 1'b0;
    wrap_s  = (presc_q == PRESC_LAST);
    if (!enable) begin
      state_d = ST_BLANK;
      blank_d = BLANK_LOAD;
    end else begin
      tick_d = wrap_s;
      if (wrap_s) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PW'(1);
      end
      if (wrap_s && !freeze) begin
        digit_d = digit_q + 2'd1;
        if (BLANK_CYCLES == 0) begin
          state_d = ST_SCAN;
        end else begin
          state_d = ST_BLANK;
          blank_d = BLANK_LOAD;
        end
      end else if (state_q == ST_BLANK) begin
        // Last dark clock is the one where the counter still reads 1 (or 0 when blanking is off)
        if (blank_q <= BW'(1)) begin
          state_d = ST_SCAN;
          blank_d = '0;
        end else begin
          blank_d = blank_q - BW'(1);
        end
      end else begin
        state_d = state_q;
      end
    end
`ifdef DISPLAY_SCAN_DIM_EN
    thr_s = (22'(brilho) + 22'd1) * 22'(DIV / 4);
    lit_s = (state_d == ST_SCAN) && (22'(presc_d) < thr_s);
`else
    lit_s = (state_d == ST_SCAN);
`endif
    if (lit_s) begin
      anodo_d = ~(4'b0001 << digit_d);
    end else begin
      anodo_d = 4'b1111;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_BLANK;
      presc_q <= '0;
      digit_q <= 2'b00;
      blank_q <= BLANK_LOAD;
      anodo_q <= 4'b1111;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      digit_q <= digit_d;
      blank_q <= blank_d;
      anodo_q <= anodo_d;
      tick_q  <= tick_d;
    end
  end

  assign saida1Contador = digit_q[1];
  assign saida2Contador = digit_q[0];
  assign anodo          = anodo_q;
  assign tick           = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (DIV=8, BLANK_CYCLES=2) against a slot-level model;
// exercises brilho when DISPLAY_SCAN_DIM_EN is defined.
module tb_display_scan_ctrl;

  localparam int DIV = 8;
  localparam int BC  = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       freeze = 1'b0;
`ifdef DISPLAY_SCAN_DIM_EN
  logic [1:0] brilho = 2'd3;
`endif
  logic       s1, s0;
  logic [3:0] anodo;
  logic       tick;

  int n_cmp = 0;
  int n_bad = 0;

  // model: position in slot, digit shown, dark clocks still owed, tick, lit threshold
  int   m_presc = 0;
  int   m_digit = 0;
  int   m_dark  = BC;
  int   m_thr   = DIV;
  logic m_tick  = 1'b0;
  bit   started = 1'b0;

  display_scan_ctrl #(.DIV(DIV), .BLANK_CYCLES(BC)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .freeze(freeze),
`ifdef DISPLAY_SCAN_DIM_EN
    .brilho(brilho),
`endif
    .saida1Contador(s1),
    .saida2Contador(s0),
    .anodo(anodo),
    .tick(tick)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_anodo();
    logic [3:0] one;
    one = 4'b0001;
    if (m_dark > 0 || m_presc >= m_thr) return 4'b1111;
    return ~(one << m_digit);
  endfunction

  // Slot-level model advanced on each rising edge from the inputs seen there
  initial forever begin
    @(posedge clock);
    started = 1'b1;
    if (reset) begin
      m_presc = 0; m_digit = 0; m_dark = BC; m_tick = 1'b0;
    end else if (!enable) begin
      m_dark = BC; m_tick = 1'b0;
    end else begin
      m_tick  = (m_presc == DIV - 1);
      m_presc = (m_presc + 1) % DIV;
      if (m_tick && !freeze) begin
        m_digit = (m_digit + 1) % 4;
        m_dark  = BC;
      end else if (m_dark > 0) begin
        m_dark = m_dark - 1;
      end
    end
`ifdef DISPLAY_SCAN_DIM_EN
    m_thr = (int'(brilho) + 1) * DIV / 4;
`else
    m_thr = DIV;
`endif
  end

  // Per-cycle comparison of all outputs against the model
  initial forever begin
    @(negedge clock);
    if (started) begin
      chk("code",  int'({s1, s0}), m_digit);
      chk("anodo", int'(anodo), int'(model_anodo()));
      chk("tick",  int'(tick), int'(m_tick));
    end
  end

  task automatic run_count(input int n, output int ticks, output int darks);
    ticks = 0;
    darks = 0;
    repeat (n) begin
      @(negedge clock);
      if (tick) ticks++;
      if (anodo == 4'b1111) darks++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d, k;
    repeat (3) @(negedge clock);
    chk("rst_anodo", int'(anodo), 4'hF);
    chk("rst_code",  int'({s1, s0}), 0);
    chk("rst_tick",  int'(tick), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("rel1_anodo", int'(anodo), 4'hF);
    @(negedge clock);
    chk("rel2_anodo", int'(anodo), 4'hE);
    chk("rel2_tick",  int'(tick), 0);

    run_count(40, t, d);
    chk("run_ticks", t, 5);
    chk("run_darks", d, 10);
    chk("run_code",  int'({s1, s0}), 1);
    chk("run_anodo", int'(anodo), 4'hD);

    enable = 1'b0;
    @(negedge clock);
    chk("dis_anodo", int'(anodo), 4'hF);
    chk("dis_code",  int'({s1, s0}), 1);
    run_count(4, t, d);
    chk("dis_ticks", t, 0);
    enable = 1'b1;
    @(negedge clock);
    chk("reen1_anodo", int'(anodo), 4'hF);
    @(negedge clock);
    chk("reen2_anodo", int'(anodo), 4'hD);

    repeat (6) @(negedge clock);
    chk("d2_code",  int'({s1, s0}), 2);
    chk("d2_anodo", int'(anodo), 4'hB);
    freeze = 1'b1;
    run_count(24, t, d);
    chk("frz_ticks", t, 3);
    chk("frz_darks", d, 0);
    chk("frz_code",  int'({s1, s0}), 2);
    freeze = 1'b0;

    repeat (6) @(negedge clock);
    chk("d3_code",  int'({s1, s0}), 3);
    chk("d3_anodo", int'(anodo), 4'hF);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_code",  int'({s1, s0}), 0);
    chk("mid_rst_anodo", int'(anodo), 4'hF);
    chk("mid_rst_tick",  int'(tick), 0);
    reset = 1'b0;
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (tick) begin
        k = i;
        break;
      end
    end
    chk("first_tick_clocks", k, 8);

`ifdef DISPLAY_SCAN_DIM_EN
    brilho = 2'd1;
    run_count(16, t, d);
    chk("dim_darks", d, 12);
    brilho = 2'd3;
    run_count(16, t, d);
    chk("full_darks", d, 4);
`endif

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
